// File: rtl/ram_bank_eraser.sv
// Fills one RAM bank with a constant pattern using fixed-length AXI4 INCR write bursts.
// The AW, W and B channels run concurrently; the number of bursts awaiting a response is bounded.
module ram_bank_eraser #(
    parameter int          DW          = 512,
    parameter int          AW          = 34,
    parameter logic [63:0] BASE_ADDR   = 64'h0,
    parameter logic [63:0] BANK_SIZE   = 64'h4_0000_0000,
    parameter int          BURST_BEATS = 64,
    parameter int          MAX_OUTST   = 8,
    parameter logic [31:0] FILL_WORD   = 32'hFFFF_FFFF
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            erase,
    output logic            idle,
    output logic            bresp_err,
    output logic [AW-1:0]   M_AXI_AWADDR,
    output logic [7:0]      M_AXI_AWLEN,
    output logic [2:0]      M_AXI_AWSIZE,
    output logic [1:0]      M_AXI_AWBURST,
    output logic            M_AXI_AWVALID,
    input  logic            M_AXI_AWREADY,
    output logic [DW-1:0]   M_AXI_WDATA,
    output logic [DW/8-1:0] M_AXI_WSTRB,
    output logic            M_AXI_WLAST,
    output logic            M_AXI_WVALID,
    input  logic            M_AXI_WREADY,
    input  logic [1:0]      M_AXI_BRESP,
    input  logic            M_AXI_BVALID,
    output logic            M_AXI_BREADY
);

    localparam logic [63:0] BURST_BYTES = 64'(BURST_BEATS) * 64'(DW / 8);
    localparam logic [63:0] NB          = BANK_SIZE / BURST_BYTES;
    localparam int          CW          = $clog2(NB + 64'd1);
    localparam int          BW          = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
    localparam logic [CW-1:0] NB_C      = CW'(NB);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_BEATS - 1);
    localparam logic [63:0] MAX_OUTST_C = 64'(MAX_OUTST);

    generate
        if ((DW % 32) != 0) begin : g_bad_dw
            $error("ram_bank_eraser: DW must be a multiple of 32");
        end
        if ((BURST_BEATS < 1) || (BURST_BEATS > 256)) begin : g_bad_beats
            $error("ram_bank_eraser: BURST_BEATS must be in 1..256");
        end
        if ((MAX_OUTST < 1) || (MAX_OUTST > 32)) begin : g_bad_outst
            $error("ram_bank_eraser: MAX_OUTST must be in 1..32");
        end
        if (((BANK_SIZE % BURST_BYTES) != 64'd0) || (NB == 64'd0)) begin : g_bad_size
            $error("ram_bank_eraser: BANK_SIZE must be a non-zero multiple of the burst size");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   aw_cnt_q, aw_cnt_d;
    logic [CW-1:0]   w_cnt_q, w_cnt_d;
    logic [CW-1:0]   b_cnt_q, b_cnt_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic            idle_q, idle_d;
    logic            bresp_err_q, bresp_err_d;
    logic            awvalid_q, awvalid_d;
    logic [AW-1:0]   awaddr_q, awaddr_d;
    logic            wvalid_q, wvalid_d;
    logic            wlast_q, wlast_d;
    logic            bready_q, bready_d;

    logic aw_fire, w_fire, b_fire;

    assign aw_fire = awvalid_q & M_AXI_AWREADY;
    assign w_fire  = wvalid_q & M_AXI_WREADY;
    assign b_fire  = bready_q & M_AXI_BVALID;

    // Constant burst attributes and fill pattern.
    assign M_AXI_AWLEN   = 8'(BURST_BEATS - 1);
    assign M_AXI_AWSIZE  = 3'($clog2(DW / 8));
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_WSTRB   = '1;

    generate
        for (genvar gi = 0; gi < DW / 32; gi++) begin : g_fill
            assign M_AXI_WDATA[gi*32 +: 32] = FILL_WORD;
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        aw_cnt_d    = aw_cnt_q;
        w_cnt_d     = w_cnt_q;
        b_cnt_d     = b_cnt_q;
        beat_d      = beat_q;
        idle_d      = idle_q;
        bresp_err_d = bresp_err_q;
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        wlast_d     = 1'b0;
        bready_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (erase) begin
                    state_d     = ST_RUN;
                    idle_d      = 1'b0;
                    aw_cnt_d    = '0;
                    w_cnt_d     = '0;
                    b_cnt_d     = '0;
                    beat_d      = '0;
                    bresp_err_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (aw_fire) begin
                    aw_cnt_d = aw_cnt_q + CW'(1);
                end
                if (w_fire) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        w_cnt_d = w_cnt_q + CW'(1);
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
                if (b_fire) begin
                    b_cnt_d = b_cnt_q + CW'(1);
                    if (M_AXI_BRESP != 2'b00) begin
                        bresp_err_d = 1'b1;
                    end
                end
                // An erase strobe arriving here (including on the final B) is dropped.
                if (b_cnt_d == NB_C) begin
                    state_d = ST_IDLE;
                    idle_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idle_d  = 1'b1;
            end
        endcase

        // Valids are derived from post-handshake counts, so a returned B frees a slot next cycle.
        if (state_d == ST_RUN) begin
            awvalid_d = (aw_cnt_d < NB_C) &&
                        ((64'(aw_cnt_d) - 64'(b_cnt_d)) < MAX_OUTST_C);
            wvalid_d  = (w_cnt_d < aw_cnt_d);
            wlast_d   = (beat_d == LAST_BEAT);
            bready_d  = 1'b1;
        end

        awaddr_d = AW'(BASE_ADDR + 64'(aw_cnt_d) * BURST_BYTES);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            aw_cnt_q    <= '0;
            w_cnt_q     <= '0;
            b_cnt_q     <= '0;
            beat_q      <= '0;
            idle_q      <= 1'b1;
            bresp_err_q <= 1'b0;
            awvalid_q   <= 1'b0;
            awaddr_q    <= AW'(BASE_ADDR);
            wvalid_q    <= 1'b0;
            wlast_q     <= 1'b0;
            bready_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            aw_cnt_q    <= aw_cnt_d;
            w_cnt_q     <= w_cnt_d;
            b_cnt_q     <= b_cnt_d;
            beat_q      <= beat_d;
            idle_q      <= idle_d;
            bresp_err_q <= bresp_err_d;
            awvalid_q   <= awvalid_d;
            awaddr_q    <= awaddr_d;
            wvalid_q    <= wvalid_d;
            wlast_q     <= wlast_d;
            bready_q    <= bready_d;
        end
    end

    assign idle          = idle_q;
    assign bresp_err     = bresp_err_q;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_WLAST   = wlast_q;
    assign M_AXI_BREADY  = bready_q;

endmodule

// File: tb/tb_ram_bank_eraser.sv
// Bench for ram_bank_eraser: a scoreboard of expected AW addresses and WLAST flags, a configurable
// AXI write slave, and a negedge monitor that checks every handshake against the scoreboard.
module tb_ram_bank_eraser;

    localparam int NBURST = 64;
    localparam int NBEATS = 256;

    logic         clk = 1'b0;
    logic         resetn;
    logic         erase;
    logic         idle;
    logic         bresp_err;
    logic [33:0]  M_AXI_AWADDR;
    logic [7:0]   M_AXI_AWLEN;
    logic [2:0]   M_AXI_AWSIZE;
    logic [1:0]   M_AXI_AWBURST;
    logic         M_AXI_AWVALID;
    logic         M_AXI_AWREADY;
    logic [511:0] M_AXI_WDATA;
    logic [63:0]  M_AXI_WSTRB;
    logic         M_AXI_WLAST;
    logic         M_AXI_WVALID;
    logic         M_AXI_WREADY;
    logic [1:0]   M_AXI_BRESP;
    logic         M_AXI_BVALID;
    logic         M_AXI_BREADY;

    ram_bank_eraser #(
        .DW(512), .AW(34), .BASE_ADDR(64'h1000), .BANK_SIZE(64'd16384),
        .BURST_BEATS(4), .MAX_OUTST(2), .FILL_WORD(32'hFFFF_FFFF)
    ) dut (
        .clk(clk), .resetn(resetn), .erase(erase), .idle(idle), .bresp_err(bresp_err),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN), .M_AXI_AWSIZE(M_AXI_AWSIZE),
        .M_AXI_AWBURST(M_AXI_AWBURST), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Scoreboard and observed-traffic state.
    logic [33:0] exp_aw_q[$];
    bit          exp_wlast_q[$];
    logic [33:0] tb_awq[$];
    bit          mem_fill[NBEATS];
    int          aw_total = 0, w_total = 0, wl_total = 0, b_total = 0, wbeat = 0;
    bit          aw_hold = 0, err_chk_next = 0;
    logic [33:0] hold_addr = '0;

    // Slave behaviour knobs.
    int aw_stall   = 0;
    bit rand_rdy   = 0;
    bit b_en       = 1;
    int err_burst  = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // AXI write slave: drives readies and B a little after each rising edge.
    initial begin
        M_AXI_AWREADY = 1'b0;
        M_AXI_WREADY  = 1'b0;
        M_AXI_BVALID  = 1'b0;
        M_AXI_BRESP   = 2'b00;
        forever begin
            @(posedge clk);
            #1;
            if (!resetn) begin
                M_AXI_AWREADY = 1'b0;
                M_AXI_WREADY  = 1'b0;
                M_AXI_BVALID  = 1'b0;
                M_AXI_BRESP   = 2'b00;
            end else begin
                if (aw_stall > 0) begin
                    M_AXI_AWREADY = 1'b0;
                    aw_stall--;
                end else begin
                    M_AXI_AWREADY = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                M_AXI_WREADY = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
                if (b_en && (wl_total > b_total)) begin
                    M_AXI_BVALID = 1'b1;
                    M_AXI_BRESP  = (b_total == err_burst) ? 2'b10 : 2'b00;
                end else begin
                    M_AXI_BVALID = 1'b0;
                    M_AXI_BRESP  = 2'b00;
                end
            end
        end
    end

    // Monitor: a valid&ready pair seen here completes on the next rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (resetn) begin
                if (err_chk_next) begin
                    chk("bresp_err_set", 64'(bresp_err), 1);
                    err_chk_next = 0;
                end
                if (aw_hold) begin
                    chk("awvalid_held", 64'(M_AXI_AWVALID), 1);
                    chk("awaddr_stable", 64'(M_AXI_AWADDR), 64'(hold_addr));
                end
                if (M_AXI_WVALID && M_AXI_WREADY) begin
                    chk("w_after_aw", 64'((w_total / 4) < aw_total), 1);
                    chk("wdata_fill", 64'(M_AXI_WDATA == {16{32'hFFFF_FFFF}}), 1);
                    chk("wstrb_ones", 64'(&M_AXI_WSTRB), 1);
                    chk("w_expected", 64'(exp_wlast_q.size() > 0), 1);
                    if (exp_wlast_q.size() > 0) chk("wlast", 64'(M_AXI_WLAST), 64'(exp_wlast_q.pop_front()));
                    if (tb_awq.size() > 0) begin
                        int idx;
                        idx = int'((tb_awq[0] - 34'h1000) >> 6) + wbeat;
                        if (idx >= 0 && idx < NBEATS) mem_fill[idx] = 1;
                    end
                    w_total++;
                    wbeat++;
                    if (M_AXI_WLAST) begin
                        wl_total++;
                        wbeat = 0;
                        if (tb_awq.size() > 0) void'(tb_awq.pop_front());
                    end
                end
                if (M_AXI_AWVALID && M_AXI_AWREADY) begin
                    chk("aw_expected", 64'(exp_aw_q.size() > 0), 1);
                    if (exp_aw_q.size() > 0) chk("awaddr", 64'(M_AXI_AWADDR), 64'(exp_aw_q.pop_front()));
                    chk("awlen", 64'(M_AXI_AWLEN), 3);
                    chk("awsize", 64'(M_AXI_AWSIZE), 6);
                    chk("awburst", 64'(M_AXI_AWBURST), 1);
                    chk("aw_outstanding", 64'((aw_total - b_total) < 2), 1);
                    tb_awq.push_back(M_AXI_AWADDR);
                    aw_total++;
                end
                aw_hold   = M_AXI_AWVALID && !M_AXI_AWREADY;
                hold_addr = M_AXI_AWADDR;
                if (M_AXI_BVALID && M_AXI_BREADY) begin
                    if (b_total == err_burst) begin
                        chk("bresp_err_before", 64'(bresp_err), 0);
                        err_chk_next = 1;
                    end
                    b_total++;
                end
            end else begin
                aw_hold      = 0;
                err_chk_next = 0;
            end
        end
    end

    task automatic clear_obs();
        exp_aw_q.delete();
        exp_wlast_q.delete();
        tb_awq.delete();
        foreach (mem_fill[i]) mem_fill[i] = 0;
        aw_total = 0; w_total = 0; wl_total = 0; b_total = 0; wbeat = 0;
    endtask

    task automatic do_erase(input string name);
        @(posedge clk);
        #1;
        clear_obs();
        for (int b = 0; b < NBURST; b++) exp_aw_q.push_back(34'h1000 + 34'(b) * 34'h100);
        for (int k = 0; k < NBEATS; k++) exp_wlast_q.push_back((k % 4) == 3);
        erase = 1'b1;
        @(negedge clk);
        chk({name, "_idle_before"}, 64'(idle), 1);
        @(posedge clk);
        #1;
        erase = 1'b0;
        @(negedge clk);
        chk({name, "_idle_fell"}, 64'(idle), 0);
        chk({name, "_bresp_err_clear"}, 64'(bresp_err), 0);
    endtask

    task automatic pulse_erase();
        @(posedge clk);
        #1;
        erase = 1'b1;
        @(posedge clk);
        #1;
        erase = 1'b0;
    endtask

    task automatic finish_run(input string name, input int budget);
        int n = 0;
        int filled = 0;
        while (idle !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_done_in_budget"}, 64'(idle), 1);
        chk({name, "_aw_total"}, 64'(aw_total), NBURST);
        chk({name, "_w_total"}, 64'(w_total), NBEATS);
        chk({name, "_b_total"}, 64'(b_total), NBURST);
        foreach (mem_fill[i]) if (mem_fill[i]) filled++;
        chk({name, "_mem_filled"}, 64'(filled), NBEATS);
        chk({name, "_aw_queue_empty"}, 64'(exp_aw_q.size()), 0);
        chk({name, "_w_queue_empty"}, 64'(exp_wlast_q.size()), 0);
        $display("[%0t] %s: erase complete aw=%0d w=%0d b=%0d cycles=%0d bresp_err=%0d",
                 $time, name, aw_total, w_total, b_total, n, bresp_err);
    endtask

    initial begin
        resetn = 1'b0;
        erase  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_idle", 64'(idle), 1);
        chk("rst_bresp_err", 64'(bresp_err), 0);
        chk("rst_awvalid", 64'(M_AXI_AWVALID), 0);
        chk("rst_wvalid", 64'(M_AXI_WVALID), 0);
        chk("rst_bready", 64'(M_AXI_BREADY), 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (2) @(posedge clk);

        // 1: always-ready slave
        do_erase("t1");
        finish_run("t1", 3000);

        // 2: AWREADY held low for 50 cycles, then random readies
        aw_stall = 50;
        rand_rdy = 1;
        do_erase("t2");
        finish_run("t2", 8000);
        rand_rdy = 0;

        // 3: B withheld, only two bursts may be outstanding
        b_en = 0;
        do_erase("t3");
        repeat (30) @(negedge clk);
        chk("t3_aw_capped", 64'(aw_total), 2);
        chk("t3_awvalid_low", 64'(M_AXI_AWVALID), 0);
        $display("[%0t] t3: stalled with aw=%0d b=%0d", $time, aw_total, b_total);
        b_en = 1;
        finish_run("t3", 3000);

        // 4: SLVERR on burst 10, erase still completes
        err_burst = 10;
        do_erase("t4");
        finish_run("t4", 3000);
        chk("t4_bresp_err_sticky", 64'(bresp_err), 1);
        err_burst = -1;

        // 5: extra erase strobes during RUN are ignored
        do_erase("t5");
        repeat (3) @(posedge clk);
        pulse_erase();
        @(negedge clk);
        chk("t5_still_running", 64'(idle), 0);
        repeat (93) @(posedge clk);
        pulse_erase();
        finish_run("t5", 3000);
        repeat (20) @(negedge clk);
        chk("t5_no_extra_aw", 64'(aw_total), NBURST);
        chk("t5_idle_stays", 64'(idle), 1);

        // 6: reset mid-erase, then a full erase
        do_erase("t6");
        begin
            int n = 0;
            while (aw_total < 20 && n < 2000) begin
                @(negedge clk);
                n++;
            end
        end
        chk("t6_reached_20_aw", 64'(aw_total >= 20), 1);
        @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        chk("t6_async_awvalid", 64'(M_AXI_AWVALID), 0);
        chk("t6_async_wvalid", 64'(M_AXI_WVALID), 0);
        chk("t6_async_bready", 64'(M_AXI_BREADY), 0);
        chk("t6_async_idle", 64'(idle), 1);
        $display("[%0t] t6: reset asserted after aw=%0d", $time, aw_total);
        clear_obs();
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (2) @(posedge clk);
        do_erase("t6b");
        finish_run("t6b", 3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
